// File: rtl/multirate_v5_pkg.sv
// Shared types and helpers for the multirate_v5 pipelined multiplier.
// Saturation helpers are used when MULTIRATE_MUL_ROUND_SAT_EN is defined.
package multirate_v5_pkg;

    localparam int MAX_DATA_W = 64;

    // One pipeline slot; data is stored sign-extended to the widest supported result.
    typedef struct packed {
        logic                  valid;
        logic                  sat;
        logic [MAX_DATA_W-1:0] data;
    } stage_t;

    function automatic int prod_width(input int w0, input int w1);
        return w0 + w1;
    endfunction

    function automatic logic signed [65:0] sat_max(input int w);
        return (66'sd1 <<< (w - 1)) - 66'sd1;
    endfunction

    function automatic logic signed [65:0] sat_min(input int w);
        return -(66'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/multirate_v5_mul_post.sv
// Post-product shift and width reduction; MULTIRATE_MUL_ROUND_SAT_EN selects
// round-half-up plus saturation instead of plain truncation.
module multirate_v5_mul_post
    import multirate_v5_pkg::*;
#(
    parameter int PW         = 26,
    parameter int DOUT_WIDTH = 26,
    parameter int SHIFT      = 0
) (
    input  logic signed [PW-1:0]         i_prod,
    output logic signed [DOUT_WIDTH-1:0] o_dout,
    output logic                         o_sat
);

    logic signed [65:0] w_res;
    logic               w_unused_hi;

`ifdef MULTIRATE_MUL_ROUND_SAT_EN
    localparam int          RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic [PW:0] RND    = (SHIFT > 0) ? ((PW + 1)'(1'b1) << RND_SH) : '0;

    logic signed [PW:0] w_sum;
    logic signed [PW:0] w_shr;
    logic signed [65:0] w_ext;

    // One extra bit keeps the rounding add from wrapping at the positive extreme.
    assign w_sum = $signed({i_prod[PW-1], i_prod}) + $signed(RND);
    assign w_shr = w_sum >>> SHIFT;
    assign w_ext = 66'(w_shr);

    // Clip to the signed output range and flag the clip.
    always_comb begin
        if (w_ext > sat_max(DOUT_WIDTH)) begin
            w_res = sat_max(DOUT_WIDTH);
            o_sat = 1'b1;
        end else if (w_ext < sat_min(DOUT_WIDTH)) begin
            w_res = sat_min(DOUT_WIDTH);
            o_sat = 1'b1;
        end else begin
            w_res = w_ext;
            o_sat = 1'b0;
        end
    end
`else
    assign w_res = 66'(i_prod >>> SHIFT);
    assign o_sat = 1'b0;
`endif

    assign o_dout      = w_res[DOUT_WIDTH-1:0];
    assign w_unused_hi = ^w_res[65:DOUT_WIDTH];

endmodule

// File: rtl/multirate_v5_mul_pipe.sv
// Pipelined signed tap x coefficient multiplier with valid/ready and bubble collapse.
// Build option MULTIRATE_MUL_ROUND_SAT_EN enables rounding/saturation in the post stage.
module multirate_v5_mul_pipe
    import multirate_v5_pkg::*;
#(
    parameter int DIN0_WIDTH = 16,
    parameter int DIN1_WIDTH = 10,
    parameter int DOUT_WIDTH = 26,
    parameter int NUM_STAGE  = 3,
    parameter int SHIFT      = 0
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic signed [DIN0_WIDTH-1:0] din0,
    input  logic signed [DIN1_WIDTH-1:0] din1,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic signed [DOUT_WIDTH-1:0] dout,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_sat
);

    localparam int PW = prod_width(DIN0_WIDTH, DIN1_WIDTH);

    stage_t                        r_stage [1:NUM_STAGE];
    stage_t                        w_next  [1:NUM_STAGE];
    logic   [NUM_STAGE:1]          w_en;
    logic signed [PW-1:0]          w_prod;
    logic signed [PW-1:0]          w_post_in;
    logic signed [DOUT_WIDTH-1:0]  w_post_dout;
    logic                          w_post_sat;
    logic                          w_unused_state;

    assign w_prod = $signed(din0) * $signed(din1);

    generate
        if (NUM_STAGE == 1) begin : g_post_on_input
            assign w_post_in = w_prod;
        end else begin : g_post_on_last
            assign w_post_in = r_stage[NUM_STAGE-1].data[PW-1:0];
        end
    endgenerate

    multirate_v5_mul_post #(
        .PW         (PW),
        .DOUT_WIDTH (DOUT_WIDTH),
        .SHIFT      (SHIFT)
    ) u_post (
        .i_prod (w_post_in),
        .o_dout (w_post_dout),
        .o_sat  (w_post_sat)
    );

    // Stage i may advance if it or any stage after it is empty, or the output drains.
    always_comb begin
        for (int i = 1; i <= NUM_STAGE; i++) begin
            logic l_all_valid;
            l_all_valid = 1'b1;
            for (int j = i; j <= NUM_STAGE; j++) begin
                l_all_valid = l_all_valid & r_stage[j].valid;
            end
            w_en[i] = out_ready | ~l_all_valid;
        end
    end

    // Value each stage loads when enabled: previous stage, with post-processing in front of the last.
    always_comb begin
        for (int i = 1; i <= NUM_STAGE; i++) begin
            w_next[i].valid = (i == 1) ? in_valid : r_stage[(i > 1) ? i - 1 : 1].valid;
            if (i == NUM_STAGE) begin
                w_next[i].sat  = w_post_sat;
                w_next[i].data = 64'(w_post_dout);
            end else if (i == 1) begin
                w_next[i].sat  = 1'b0;
                w_next[i].data = 64'(w_prod);
            end else begin
                w_next[i].sat  = r_stage[(i > 1) ? i - 1 : 1].sat;
                w_next[i].data = r_stage[(i > 1) ? i - 1 : 1].data;
            end
        end
    end

    // Pipeline registers; reset discards anything in flight.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int i = 1; i <= NUM_STAGE; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            for (int i = 1; i <= NUM_STAGE; i++) begin
                if (w_en[i]) begin
                    r_stage[i] <= w_next[i];
                end
            end
        end
    end

    // Folds storage bits that only some stages consume (upper data bits, early sat flags).
    always_comb begin
        w_unused_state = 1'b0;
        for (int i = 1; i <= NUM_STAGE; i++) begin
            w_unused_state = w_unused_state ^ (^r_stage[i]);
        end
    end

    assign in_ready  = w_en[1];
    assign out_valid = r_stage[NUM_STAGE].valid;
    assign out_sat   = r_stage[NUM_STAGE].sat;
    assign dout      = r_stage[NUM_STAGE].data[DOUT_WIDTH-1:0];

endmodule

// File: tb/tb_multirate_v5_mul_pipe.sv
// Directed self-checking bench for multirate_v5_mul_pipe; a second instance with
// DOUT_WIDTH=16, SHIFT=8 checks truncation, or rounding/saturation under MULTIRATE_MUL_ROUND_SAT_EN.
module tb_multirate_v5_mul_pipe;

    logic               clk = 1'b0;
    logic               rst_n;
    logic signed [15:0] din0;
    logic signed [9:0]  din1;
    logic               in_valid;
    logic               out_ready;
    logic               in_ready,   out_valid,   out_sat;
    logic               in_ready_b, out_valid_b, out_sat_b;
    logic signed [25:0] dout;
    logic signed [15:0] dout_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    multirate_v5_mul_pipe u_dut (
        .ap_clk(clk), .ap_rst_n(rst_n), .din0(din0), .din1(din1),
        .in_valid(in_valid), .in_ready(in_ready), .dout(dout),
        .out_valid(out_valid), .out_ready(out_ready), .out_sat(out_sat)
    );

    multirate_v5_mul_pipe #(.DOUT_WIDTH(16), .SHIFT(8)) u_dut_b (
        .ap_clk(clk), .ap_rst_n(rst_n), .din0(din0), .din1(din1),
        .in_valid(in_valid), .in_ready(in_ready_b), .dout(dout_b),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_sat(out_sat_b)
    );

    task automatic check_value(input string tag, input logic signed [63:0] got,
                               input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One beat through an empty pipe with out_ready held high.
    task automatic run_beat(input string tag, input int a, input int b, input longint exp_a,
                            input longint exp_b_tr, input longint exp_b_rs, input bit sat_rs);
        int lat;
        @(negedge clk);
        din0 = 16'(a); din1 = 10'(b); in_valid = 1'b1; out_ready = 1'b1;
        #1 check_value({tag, "_in_ready"}, in_ready, 1);
        check_value({tag, "_in_ready_b"}, in_ready_b, 1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check_value({tag, "_latency"}, lat, 3);
        check_value({tag, "_dout"}, $signed(dout), exp_a);
        check_value({tag, "_sat"}, out_sat, 0);
        check_value({tag, "_valid_b"}, out_valid_b, 1);
`ifdef MULTIRATE_MUL_ROUND_SAT_EN
        check_value({tag, "_dout_b"}, $signed(dout_b), exp_b_rs);
        check_value({tag, "_sat_b"}, out_sat_b, 64'(sat_rs));
`else
        check_value({tag, "_dout_b"}, $signed(dout_b), exp_b_tr);
        check_value({tag, "_sat_b"}, out_sat_b, 0);
`endif
        @(negedge clk);
        check_value({tag, "_drained"}, out_valid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int sent, recv;
        bit stalled;
        logic signed [63:0] held;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; din0 = '0; din1 = '0;
        #2;
        check_value("rst_out_valid", out_valid, 0);
        check_value("rst_dout", $signed(dout), 0);
        check_value("rst_out_sat", out_sat, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_value("rst_in_ready", in_ready, 1);

        run_beat("basic",    1234,  -300, -370200,   -1447, -1446,  1'b0);
        run_beat("corner", -32768,  -512, 16777216,      0, 32767,  1'b1);
        run_beat("maxpos",  32767,   511, 16743937,   -130, 32767,  1'b1);
        run_beat("half",      384,     1, 384,           1,     2,  1'b0);
        run_beat("neghalf",  -384,     1, -384,         -2,    -1,  1'b0);
        run_beat("maxneg", -32768,   511, -16744448,   128, -32768, 1'b1);

        // Backpressure: 8 beats of k*3, output stalled for cycles 4..9.
        sent = 0; recv = 0; stalled = 1'b0; held = '0;
        for (int c = 0; c < 40 && recv < 8; c++) begin
            @(negedge clk);
            out_ready = !(c >= 4 && c <= 9);
            in_valid  = (sent < 8);
            din0 = 16'(sent + 1); din1 = 10'sd3;
            #1;
            if (stalled) check_value("bp_hold", $signed(dout), held);
            if (c >= 4 && c <= 9) check_value("bp_in_ready", in_ready, 0);
            if (out_valid && out_ready) begin
                check_value("bp_order", $signed(dout), 64'(3 * (recv + 1)));
                recv++;
            end
            stalled = out_valid && !out_ready;
            held    = $signed(dout);
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0;
        check_value("bp_count", recv, 8);
        repeat (4) @(negedge clk);

        // Bubble collapse: A, gap, B, gap, C with the output stalled.
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            out_ready = (c >= 6);
            in_valid  = (c == 0 || c == 2 || c == 4);
            din0 = (c == 0) ? 16'sd7 : (c == 2) ? -16'sd100 : 16'sd3;
            din1 = (c == 0) ? -10'sd2 : (c == 2) ? 10'sd5 : 10'sd3;
            #1;
            if (c <= 4) check_value("bub_in_ready", in_ready, 1);
            if (c == 5) check_value("bub_full", in_ready, 0);
            if (c == 4 || c == 5 || c == 6) check_value("bub_a", $signed(dout), -14);
            if (c == 7) check_value("bub_b", $signed(dout), -500);
            if (c == 8) check_value("bub_c", $signed(dout), 9);
            if (c >= 4) check_value("bub_valid", out_valid, 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);

        // Asynchronous reset with three beats in flight.
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            in_valid = 1'b1; din0 = 16'(11 + c); din1 = 10'sd2;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1 check_value("mid_valid", out_valid, 1);
        check_value("mid_dout", $signed(dout), 22);
        #1 rst_n = 1'b0;
        #1 check_value("arst_valid", out_valid, 0);
        check_value("arst_dout", $signed(dout), 0);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1 check_value("arst_no_stale", out_valid, 0);
        end

        run_beat("post_rst", -7, 9, -63, -1, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
